// File: rtl/ot_pkg.sv
// Shared types and constants for the quantize-to-output-buffer packer.
package ot_pkg;

  // Packer state: IDLE means no lane of the current word has been written yet.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } pack_state_e;

  localparam int unsigned DEF_DW         = 8;
  localparam int unsigned DEF_LANES      = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  // Bits needed to index 'value' items; never less than 1 so vectors stay legal.
  function automatic int unsigned ot_clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < value) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/ot_pack_fifo.sv
// Small synchronous FIFO holding packed words; head output holds its last
// popped value while empty.
module ot_pack_fifo
  import ot_pkg::*;
#(
  parameter int unsigned W     = 73,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned AW   = ot_clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [W-1:0]  last_q;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign dout_o  = empty_o ? last_q : mem_q[rd_ptr_q];

  // Storage array; written only on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers (power-of-two depth wraps naturally), occupancy and held head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ot_qtbuf_pack.sv
// Gathers DW-bit quantized samples into LANES-wide words, supports early
// flush with lane keep, and drains words through a small FIFO.
module ot_qtbuf_pack
  import ot_pkg::*;
#(
  parameter int unsigned DW         = DEF_DW,
  parameter int unsigned LANES      = DEF_LANES,
  parameter int unsigned OUT_W      = DW * LANES,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DW-1:0]    q_out,
  input  logic             q_valid,
  input  logic             q_last,
  output logic             q_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [LANES-1:0] out_keep,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_cnt,
  output logic             busy
);

  localparam int unsigned LW = ot_clog2(LANES);
  localparam int unsigned CW = ot_clog2(FIFO_DEPTH);
  localparam int unsigned FW = OUT_W + LANES + 1;

  pack_state_e      state_q, state_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [OUT_W-1:0] acc_q, acc_d, acc_with;
  logic [LANES-1:0] keep_q, keep_d, keep_with;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic          accept, close, pop;
  logic          fifo_full, fifo_empty;
  logic [CW:0]   fifo_count;
  logic [FW-1:0] fifo_din, fifo_dout;

  assign q_ready   = ~fifo_full;
  assign out_valid = ~fifo_empty;
  assign accept    = q_valid & q_ready;
  assign pop       = out_valid & out_ready;
  assign close     = accept & (q_last | (lane_q == LW'(LANES - 1)));
  assign busy      = (lane_q != '0) | (fifo_count != '0);
  assign word_cnt  = word_cnt_q;

  // Current accumulator with the incoming sample merged into its lane; the
  // keep bit sits at the same lane position as the sample's data bytes.
  always_comb begin
    acc_with  = acc_q;
    keep_with = keep_q;
    for (int k = 0; k < int'(LANES); k++) begin
      if (LW'(k) == lane_q) begin
        if (MSB_FIRST) begin
          acc_with[(int'(LANES) - 1 - k) * int'(DW) +: DW] = q_out;
          keep_with[int'(LANES) - 1 - k]                   = 1'b1;
        end else begin
          acc_with[k * int'(DW) +: DW] = q_out;
          keep_with[k]                 = 1'b1;
        end
      end
    end
  end

  // Next-state logic: a closing beat clears the word, otherwise advance a lane.
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    acc_d      = acc_q;
    keep_d     = keep_q;
    word_cnt_d = word_cnt_q + (pop ? CNT_W'(1) : CNT_W'(0));
    if (accept) begin
      if (close) begin
        state_d = ST_IDLE;
        lane_d  = '0;
        acc_d   = '0;
        keep_d  = '0;
      end else begin
        state_d = ST_FILL;
        lane_d  = lane_q + LW'(1);
        acc_d   = acc_with;
        keep_d  = keep_with;
      end
    end
  end

  // Packer FSM, accumulator and popped-word counter; reset drops any partial word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      lane_q     <= '0;
      acc_q      <= '0;
      keep_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      acc_q      <= acc_d;
      keep_q     <= keep_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign fifo_din = {acc_with, keep_with, q_last};

  ot_pack_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (close),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign out_data = fifo_dout[FW-1 -: OUT_W];
  assign out_keep = fifo_dout[LANES:1];
  assign out_last = fifo_dout[0];

endmodule

// File: tb/tb_ot_qtbuf_pack.sv
// Directed bench for ot_qtbuf_pack: MSB-first and LSB-first instances share stimulus.
module tb_ot_qtbuf_pack;

  logic        clk;
  logic        reset;
  logic [7:0]  q_out;
  logic        q_valid, q_last, out_ready;

  logic        q_ready, out_last, out_valid, busy;
  logic [63:0] out_data;
  logic [7:0]  out_keep;
  logic [15:0] word_cnt;

  logic        q_ready2, out_last2, out_valid2, busy2;
  logic [63:0] out_data2;
  logic [7:0]  out_keep2;
  logic [15:0] word_cnt2;

  int checks = 0;
  int errors = 0;

  ot_qtbuf_pack #(.MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .q_out(q_out), .q_valid(q_valid), .q_last(q_last),
    .q_ready(q_ready), .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .word_cnt(word_cnt), .busy(busy)
  );

  ot_qtbuf_pack #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .q_out(q_out), .q_valid(q_valid), .q_last(q_last),
    .q_ready(q_ready2), .out_data(out_data2), .out_keep(out_keep2), .out_last(out_last2),
    .out_valid(out_valid2), .out_ready(out_ready), .word_cnt(word_cnt2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    q_valid = 1'b1;
    q_out   = d;
    q_last  = l;
    tick();
    q_valid = 1'b0;
    q_last  = 1'b0;
  endtask

  task automatic apply_reset();
    #2;
    reset   = 1'b0;
    q_valid = 1'b0;
    q_last  = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Scoreboard for the streaming phase: bytes are packed MSB-first by the bench.
  logic [63:0] expq[$];
  logic [63:0] cur;
  int          lanes;
  int          pops;

  task automatic sb_step();
    logic [63:0] e;
    if (out_valid && out_ready) begin
      pops++;
      chk("sb_pop_avail", 64'(expq.size() > 0), 64'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("sb_word", out_data, e);
      end
    end
    if (q_valid && q_ready) begin
      cur[8*(7-lanes) +: 8] = q_out;
      lanes++;
      if (lanes == 8) begin
        expq.push_back(cur);
        cur   = '0;
        lanes = 0;
      end
    end
  endtask

  logic [63:0] w4 [4];
  int          acc_n, first_low, fullpops;
  logic        prev_fp;

  initial begin
    reset = 1'b0; q_out = '0; q_valid = 1'b0; q_last = 1'b0; out_ready = 1'b1;
    cur = '0; lanes = 0; pops = 0;
    w4[0] = 64'h3031323334353637;
    w4[1] = 64'h38393A3B3C3D3E3F;
    w4[2] = 64'h4041424344454647;
    w4[3] = 64'h48494A4B4C4D4E4F;

    // Reset state
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_keep", out_keep, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_q_ready", q_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_word_cnt", word_cnt, 0);
    reset = 1'b1;
    tick();

    // Test 1/2: full word, both lane orders
    for (int i = 1; i <= 8; i++) begin
      beat(8'(i), 1'b0);
      if (i == 3) begin
        chk("t1_busy_partial", busy, 1);
        chk("t1_valid_partial", out_valid, 0);
      end
    end
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 64'h0102030405060708);
    chk("t1_keep", out_keep, 8'hFF);
    chk("t1_last", out_last, 0);
    chk("t2_data_lsb", out_data2, 64'h0807060504030201);
    chk("t2_keep_lsb", out_keep2, 8'hFF);
    tick();
    chk("t1_valid_one_cycle", out_valid, 0);
    chk("t1_word_cnt", word_cnt, 1);
    chk("t1_data_hold", out_data, 64'h0102030405060708);

    // Test 3: flush with partial keep, then next beat lands in lane 0
    beat(8'hAA, 1'b0);
    beat(8'hBB, 1'b0);
    beat(8'hCC, 1'b1);
    chk("t3_data", out_data, 64'hAABBCC0000000000);
    chk("t3_keep", out_keep, 8'hE0);
    chk("t3_last", out_last, 1);
    chk("t3_data_lsb", out_data2, 64'h0000000000CCBBAA);
    chk("t3_keep_lsb", out_keep2, 8'h07);
    tick();
    chk("t3_word_cnt", word_cnt, 2);
    chk("t3_busy_idle", busy, 0);
    beat(8'h5A, 1'b1);
    chk("t3_next_lane0_data", out_data, 64'h5A00000000000000);
    chk("t3_next_lane0_keep", out_keep, 8'h80);
    tick();

    // Test 4: backpressure fills the FIFO, then drain in order
    apply_reset();
    out_ready = 1'b0;
    acc_n = 0;
    first_low = -1;
    for (int c = 0; c < 40; c++) begin
      q_valid = 1'b1;
      q_out   = 8'h30 + 8'(acc_n);
      if (q_ready) acc_n++;
      else if (first_low < 0) first_low = c;
      tick();
    end
    q_valid = 1'b0;
    chk("t4_accepted", 64'(acc_n), 32);
    chk("t4_ready_drop_cycle", 64'(first_low), 32);
    chk("t4_q_ready_low", q_ready, 0);
    chk("t4_busy", busy, 1);
    chk("t4_no_pop_cnt", word_cnt, 0);
    tick(); tick();
    chk("t4_head_stable", out_data, w4[0]);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t4_drain_valid", out_valid, 1);
      chk("t4_drain_data", out_data, w4[k]);
      chk("t4_drain_keep", out_keep, 8'hFF);
      tick();
    end
    chk("t4_empty", out_valid, 0);
    chk("t4_word_cnt", word_cnt, 4);
    chk("t4_q_ready_back", q_ready, 1);

    // Test 5: simultaneous push/pop around full
    apply_reset();
    out_ready = 1'b0;
    q_valid   = 1'b1;
    cur = '0; lanes = 0; pops = 0;
    expq.delete();
    for (int c = 0; c < 40 && q_ready; c++) begin
      q_out = 8'($urandom_range(0, 255));
      sb_step();
      tick();
    end
    chk("t5_full", q_ready, 0);
    chk("t5_queued", 64'(expq.size()), 4);
    fullpops = 0;
    prev_fp  = 1'b0;
    for (int c = 0; c < 96; c++) begin
      out_ready = (c % 9 == 0);
      q_out     = 8'($urandom_range(0, 255));
      if (prev_fp) chk("t5_ready_after_fullpop", q_ready, 1);
      prev_fp = !q_ready && out_ready;
      if (prev_fp) fullpops++;
      sb_step();
      tick();
    end
    q_valid   = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && out_valid; c++) begin
      sb_step();
      tick();
    end
    chk("t5_fullpop_events", 64'(fullpops >= 3), 1);
    chk("t5_drained", out_valid, 0);
    chk("t5_sb_empty", 64'(expq.size()), 0);
    chk("t5_word_cnt", word_cnt, 16'(pops));
    chk("t5_busy_partial", busy, 64'(lanes != 0));

    // Test 6: reset mid-word discards queued and partial data
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) beat(8'h61 + 8'(i), 1'b0);
    for (int i = 0; i < 5; i++) beat(8'h71 + 8'(i), 1'b0);
    chk("t6_pre_valid", out_valid, 1);
    chk("t6_pre_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_word_cnt", word_cnt, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_q_ready", q_ready, 1);
    tick();
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) beat(8'h11 + 8'(i), 1'b0);
    chk("t6_data", out_data, 64'h1112131415161718);
    chk("t6_keep", out_keep, 8'hFF);
    chk("t6_last", out_last, 0);
    tick();
    chk("t6_word_cnt", word_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
